// File: rtl/bcd_down_counter_if.sv
// Bus interface for bcd_down_counter.
//   master: drives En, load, D; observes Q, Z, busy, done, err.
//   slave : the counter itself.
// Ports carried:
//   En   - count enable (only acts in RUN)
//   load - parallel load strobe
//   D    - BCD load value, digit 0 in bits [3:0]
//   Q    - current count, BCD, registered
//   Z    - Q equals zero
//   busy - counter is in RUN
//   done - one-cycle expiry pulse
//   err  - sticky invalid-load flag
interface bcd_down_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  En;
    logic                  load;
    logic [4*DIGITS-1:0]   D;
    logic [4*DIGITS-1:0]   Q;
    logic                  Z;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output En, load, D,
        input  Q, Z, busy, done, err
    );

    modport slave (
        input  En, load, D,
        output Q, Z, busy, done, err
    );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter/timer with parallel load, expiry pulse and
// a three-state control FSM (IDLE / RUN / EXPIRED).
//
// Parameters:
//   DIGITS - number of BCD digits (1..4); must match the interface instance.
// Ports:
//   clk    - clock, rising edge
//   clear  - synchronous active-high reset, highest priority
//   bus    - bcd_down_counter_if.slave (En, load, D, Q, Z, busy, done, err)
//
// Optional feature macro: BCD_DOWN_AUTORELOAD_EN
//   When defined, the last valid non-zero load value is kept in a reload
//   register and expiry reloads it instead of stopping, so counting is
//   periodic and EXPIRED is never entered. Undefined: one-shot counting.
module bcd_down_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                clk,
    input  logic                clear,
    bcd_down_counter_if.slave   bus
);
    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         state, state_next;
    state_t         expire_state;
    logic [W-1:0]   q, q_next, dec, expire_value;
    logic           done, done_next;
    logic           err, err_next;
    logic           d_valid, d_zero, dec_zero, borrow;

    // Load value checks: every nibble must be a decimal digit.
    always_comb begin : load_decode
        d_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.D[4*i +: 4] > 4'd9) d_valid = 1'b0;
        end
        d_zero = (bus.D == '0);
    end

    // BCD decrement: ripple a borrow up from digit 0; a digit at 0 wraps
    // to 9 and keeps borrowing. Only used in RUN, where q is never zero.
    always_comb begin : bcd_decrement
        dec    = q;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (q[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        dec_zero = (dec == '0);
    end

`ifdef BCD_DOWN_AUTORELOAD_EN
    logic [W-1:0] reload;

    always_ff @(posedge clk) begin
        if (clear) begin
            reload <= '0;
        end else if (bus.load && d_valid && !d_zero) begin
            reload <= bus.D;
        end
    end

    // Expiry restarts the period from the reload value and stays in RUN.
    assign expire_value = reload;
    assign expire_state = RUN;
`else
    assign expire_value = '0;
    assign expire_state = EXPIRED;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
            q     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            done  <= done_next;
            err   <= err_next;
        end
    end

    // Next-state logic. An invalid load leaves Q and state untouched and
    // also suppresses counting on that edge, since load outranks En.
    always_comb begin : next_state
        state_next = state;
        q_next     = q;
        done_next  = 1'b0;
        err_next   = err;
        if (bus.load) begin
            if (d_valid) begin
                err_next   = 1'b0;
                q_next     = bus.D;
                state_next = d_zero ? IDLE : RUN;
            end else begin
                err_next   = 1'b1;
            end
        end else if (state == RUN && bus.En) begin
            if (dec_zero) begin
                q_next     = expire_value;
                state_next = expire_state;
                done_next  = 1'b1;
            end else begin
                q_next     = dec;
            end
        end
    end

    // Outputs.
    always_comb begin : outputs
        bus.Q    = q;
        bus.Z    = (q == '0);
        bus.busy = (state == RUN);
        bus.done = done;
        bus.err  = err;
    end
endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS = 2).
// Table of single-edge vectors plus a multi-cycle countdown sequence.
// Build with +define+BCD_DOWN_AUTORELOAD_EN to check the periodic variant.
module tb_bcd_down_counter;
    logic clk   = 1'b0;
    logic clear = 1'b0;

    bcd_down_counter_if #(.DIGITS(2)) bus ();

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clear;
        logic       load;
        logic       en;
        logic [7:0] d;
        logic [7:0] q;
        logic       z;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(string name, logic c, logic l, logic e,
                                logic [7:0] d, logic [7:0] q, logic z,
                                logic b, logic dn, logic er);
        vec_t v;
        v.name = name; v.clear = c; v.load = l; v.en = e; v.d = d;
        v.q = q; v.z = z; v.busy = b; v.done = dn; v.err = er;
        vecs.push_back(v);
    endfunction

    task automatic check_outputs(string name, logic [7:0] q, logic z,
                                 logic b, logic dn, logic er);
        checks++;
        if ({bus.Q, bus.Z, bus.busy, bus.done, bus.err} !== {q, z, b, dn, er}) begin
            errors++;
            $display("FAIL %s: got Q=%h Z=%b busy=%b done=%b err=%b, expected Q=%h Z=%b busy=%b done=%b err=%b",
                     name, bus.Q, bus.Z, bus.busy, bus.done, bus.err, q, z, b, dn, er);
        end
    endtask

    task automatic drive(logic c, logic l, logic e, logic [7:0] d);
        @(negedge clk);
        clear  = c;
        bus.load = l;
        bus.En = e;
        bus.D  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  edges;
        int  done_seen;
        logic prev_done;

        bus.load = 1'b0;
        bus.En   = 1'b0;
        bus.D    = '0;

        //  name             clr ld en  D      Q      Z  busy done err
        add("reset",         1, 1, 1, 8'h42, 8'h00, 1, 0, 0, 0);
        add("load21",        0, 1, 1, 8'h21, 8'h21, 0, 1, 0, 0);
        add("dec20",         0, 0, 1, 8'h00, 8'h20, 0, 1, 0, 0);
        add("borrow19",      0, 0, 1, 8'h00, 8'h19, 0, 1, 0, 0);
        add("dec18",         0, 0, 1, 8'h00, 8'h18, 0, 1, 0, 0);
        add("load10",        0, 1, 0, 8'h10, 8'h10, 0, 1, 0, 0);
        add("borrow09",      0, 0, 1, 8'h00, 8'h09, 0, 1, 0, 0);
        add("hold_en0",      0, 0, 0, 8'h00, 8'h09, 0, 1, 0, 0);
        add("load99",        0, 1, 0, 8'h99, 8'h99, 0, 1, 0, 0);
        add("dec98",         0, 0, 1, 8'h00, 8'h98, 0, 1, 0, 0);
        add("load03",        0, 1, 0, 8'h03, 8'h03, 0, 1, 0, 0);
        add("exp02",         0, 0, 1, 8'h00, 8'h02, 0, 1, 0, 0);
        add("exp01",         0, 0, 1, 8'h00, 8'h01, 0, 1, 0, 0);
`ifdef BCD_DOWN_AUTORELOAD_EN
        add("reload03",      0, 0, 1, 8'h00, 8'h03, 0, 1, 1, 0);
        add("after_reload",  0, 0, 1, 8'h00, 8'h02, 0, 1, 0, 0);
        add("ar_load02",     0, 1, 0, 8'h02, 8'h02, 0, 1, 0, 0);
        add("ar_01",         0, 0, 1, 8'h00, 8'h01, 0, 1, 0, 0);
        add("ar_02",         0, 0, 1, 8'h00, 8'h02, 0, 1, 1, 0);
        add("ar_01b",        0, 0, 1, 8'h00, 8'h01, 0, 1, 0, 0);
        add("ar_02b",        0, 0, 1, 8'h00, 8'h02, 0, 1, 1, 0);
        add("ar_load01",     0, 1, 0, 8'h01, 8'h01, 0, 1, 0, 0);
        add("ar_1_a",        0, 0, 1, 8'h00, 8'h01, 0, 1, 1, 0);
        add("ar_1_b",        0, 0, 1, 8'h00, 8'h01, 0, 1, 1, 0);
`else
        add("exp00_done",    0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 0);
        add("expired_hold",  0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
        add("load01",        0, 1, 0, 8'h01, 8'h01, 0, 1, 0, 0);
        add("exp_from01",    0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 0);
        add("done_single",   0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
`endif
        add("load57",        0, 1, 0, 8'h57, 8'h57, 0, 1, 0, 0);
        add("bad_load5A",    0, 1, 0, 8'h5A, 8'h57, 0, 1, 0, 1);
        add("cont56",        0, 0, 1, 8'h00, 8'h56, 0, 1, 0, 1);
        add("load12_clrerr", 0, 1, 0, 8'h12, 8'h12, 0, 1, 0, 0);
        add("load02",        0, 1, 0, 8'h02, 8'h02, 0, 1, 0, 0);
        add("to01",          0, 0, 1, 8'h00, 8'h01, 0, 1, 0, 0);
        add("load_at_exp",   0, 1, 1, 8'h30, 8'h30, 0, 1, 0, 0);
        add("load44",        0, 1, 0, 8'h44, 8'h44, 0, 1, 0, 0);
        add("clear_mid",     1, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
        add("load05",        0, 1, 0, 8'h05, 8'h05, 0, 1, 0, 0);
        add("dec04",         0, 0, 1, 8'h00, 8'h04, 0, 1, 0, 0);
        add("load00_idle",   0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0);
        add("idle_ign_en",   0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0);
        add("bad_loadF0",    0, 1, 0, 8'hF0, 8'h00, 1, 0, 0, 1);
        add("err_sticky",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 1);
        add("clear_err",     1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].clear, vecs[i].load, vecs[i].en, vecs[i].d);
            check_outputs(vecs[i].name, vecs[i].q, vecs[i].z,
                          vecs[i].busy, vecs[i].done, vecs[i].err);
        end

        // Long countdown with En held high: load 12 (BCD) then count edges.
`ifdef BCD_DOWN_AUTORELOAD_EN
        drive(0, 1, 0, 8'h03);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1, 8'h00);
            if (bus.done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 2 || bus.Q !== 8'h03 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL periodic: got done_count=%0d Q=%h busy=%b, expected done_count=2 Q=03 busy=1",
                     done_seen, bus.Q, bus.busy);
        end
`else
        drive(0, 1, 0, 8'h12);
        edges     = 0;
        done_seen = 0;
        prev_done = 1'b0;
        while (edges < 40 && bus.Q !== 8'h00) begin
            drive(0, 0, 1, 8'h00);
            edges++;
            if (bus.done === 1'b1 && bus.Q !== 8'h00) done_seen++;
            prev_done = bus.done;
        end
        checks++;
        if (edges != 12 || prev_done !== 1'b1 || bus.busy !== 1'b0 || done_seen != 0) begin
            errors++;
            $display("FAIL countdown12: got edges=%0d done=%b busy=%b early_done=%0d, expected edges=12 done=1 busy=0 early_done=0",
                     edges, prev_done, bus.busy, done_seen);
        end
        drive(0, 0, 1, 8'h00);
        check_outputs("countdown12_after", 8'h00, 1, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
